// File: rtl/rs232_frame_ctrl.sv
// rs232_frame_ctrl: frame parser behind the rs232_rx byte receiver.
// Hunts for SyncByte and parses SYNC, LEN, PAYLOAD[LEN], CHK frames, where CHK is
// the XOR of LEN and every payload byte. A validated payload is held for the host
// until ack_i. Rejected frames report their cause, and parity errors are counted.
module rs232_frame_ctrl #(
  parameter int unsigned MaxLen     = 8,
  parameter logic [7:0]  SyncByte   = 8'hA5,
  parameter int unsigned TimeoutCyc = 229166,
  parameter int unsigned TimeoutW   = 18
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       pcheck_i,
  input  logic       eor_i,
  input  logic [3:0] rd_addr_i,
  input  logic       ack_i,
  output logic [7:0] rd_data_o,
  output logic [3:0] len_o,
  output logic       frame_vld_o,
  output logic       frame_err_o,
  output logic [2:0] err_code_o,
  output logic       overrun_o,
  output logic [7:0] perr_cnt_o
);

  localparam int unsigned AW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  // The counter runs from 0 after a strobe; the error is taken on the edge where it would reach TimeoutCyc-1.
  localparam logic [TimeoutW-1:0] TmoLast = TimeoutW'(TimeoutCyc - 2);

  localparam logic [2:0] ErrNone   = 3'd0;
  localparam logic [2:0] ErrParity = 3'd1;
  localparam logic [2:0] ErrLength = 3'd2;
  localparam logic [2:0] ErrChk    = 3'd3;
  localparam logic [2:0] ErrTmo    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_t;

  state_t                state_q;
  logic [7:0]            pay_q [MaxLen];
  logic [3:0]            len_q;
  logic [3:0]            idx_q;
  logic [7:0]            chk_q;
  logic [TimeoutW-1:0]   tmo_q;

  logic                  in_frame;
  logic                  is_sync;
  logic                  reject;
  logic [2:0]            rej_code;

  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign is_sync  = eor_i && pcheck_i && (byte_i == SyncByte);

  // Rejection decision for the in-frame states; parity outranks length/checksum, a strobe outranks timeout.
  always_comb begin
    reject   = 1'b0;
    rej_code = ErrNone;
    if (in_frame) begin
      if (eor_i) begin
        if (!pcheck_i) begin
          reject   = 1'b1;
          rej_code = ErrParity;
        end else if ((state_q == S_LEN) && ((byte_i == 8'd0) || (byte_i > 8'(MaxLen)))) begin
          reject   = 1'b1;
          rej_code = ErrLength;
        end else if ((state_q == S_CHK) && (byte_i != chk_q)) begin
          reject   = 1'b1;
          rej_code = ErrChk;
        end
      end else if (tmo_q == TmoLast) begin
        reject   = 1'b1;
        rej_code = ErrTmo;
      end
    end
  end

  // Host read port: only the held payload is visible, anything past len_o reads as 0.
  always_comb begin
    rd_data_o = '0;
    if (rd_addr_i < len_o) rd_data_o = pay_q[rd_addr_i[AW-1:0]];
  end

  // Frame state machine with registered status outputs, timeout counter and parity error counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      len_o       <= '0;
      frame_vld_o <= 1'b0;
      frame_err_o <= 1'b0;
      err_code_o  <= ErrNone;
      overrun_o   <= 1'b0;
      perr_cnt_o  <= '0;
    end else begin
      frame_err_o <= 1'b0;

      if (eor_i && !pcheck_i && (perr_cnt_o != 8'hFF)) perr_cnt_o <= perr_cnt_o + 8'd1;

      if (eor_i || !in_frame) tmo_q <= '0;
      else                    tmo_q <= tmo_q + TimeoutW'(1);

      case (state_q)
        S_IDLE: begin
          if (is_sync) begin
            state_q <= S_LEN;
            chk_q   <= '0;
          end
        end

        S_LEN, S_PAYLOAD, S_CHK: begin
          if (reject) begin
            state_q     <= S_IDLE;
            frame_err_o <= 1'b1;
            err_code_o  <= rej_code;
          end else if (eor_i) begin
            case (state_q)
              S_LEN: begin
                len_q   <= byte_i[3:0];
                chk_q   <= byte_i;
                idx_q   <= '0;
                state_q <= S_PAYLOAD;
              end
              S_PAYLOAD: begin
                pay_q[idx_q[AW-1:0]] <= byte_i;
                chk_q <= chk_q ^ byte_i;
                idx_q <= idx_q + 4'd1;
                if (idx_q == len_q - 4'd1) state_q <= S_CHK;
              end
              S_CHK: begin
                state_q     <= S_HOLD;
                frame_vld_o <= 1'b1;
                err_code_o  <= ErrNone;
                len_o       <= len_q;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end

        S_HOLD: begin
          if (ack_i) begin
            state_q     <= S_IDLE;
            frame_vld_o <= 1'b0;
            overrun_o   <= 1'b0;
            len_o       <= '0;
          end else if (is_sync) begin
            overrun_o <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_frame_ctrl.sv
// Self-checking bench for rs232_frame_ctrl: a byte-list frame model compared every
// cycle, plus literal expectations for the directed frames.
module tb_rs232_frame_ctrl;

  localparam int         MAXLEN = 8;
  localparam int         TMO    = 40;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_i = '0;
  logic       pcheck_i = 1'b0;
  logic       eor_i = 1'b0;
  logic [3:0] rd_addr_i = '0;
  logic       ack_i = 1'b0;
  logic [7:0] rd_data_o;
  logic [3:0] len_o;
  logic       frame_vld_o;
  logic       frame_err_o;
  logic [2:0] err_code_o;
  logic       overrun_o;
  logic [7:0] perr_cnt_o;

  always #5 clk = ~clk;

  rs232_frame_ctrl #(
    .MaxLen    (MAXLEN),
    .SyncByte  (SYNC),
    .TimeoutCyc(TMO),
    .TimeoutW  (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .byte_i     (byte_i),
    .pcheck_i   (pcheck_i),
    .eor_i      (eor_i),
    .rd_addr_i  (rd_addr_i),
    .ack_i      (ack_i),
    .rd_data_o  (rd_data_o),
    .len_o      (len_o),
    .frame_vld_o(frame_vld_o),
    .frame_err_o(frame_err_o),
    .err_code_o (err_code_o),
    .overrun_o  (overrun_o),
    .perr_cnt_o (perr_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes of the frame being collected (empty = hunting), plus held payload.
  logic [7:0] fq[$];
  logic [7:0] m_pay[$];
  bit         m_hold, m_vld, m_err, m_ovr;
  int         m_code, m_len, m_perr, m_idle;

  function automatic void m_reject(input int c);
    fq.delete();
    m_err  = 1;
    m_code = c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete(); m_pay.delete();
      m_hold = 0; m_vld = 0; m_err = 0; m_ovr = 0;
      m_code = 0; m_len = 0; m_perr = 0; m_idle = 0;
    end else begin
      m_err = 0;
      if (eor_i && !pcheck_i && m_perr < 255) m_perr++;
      if (m_hold) begin
        if (ack_i) begin
          m_hold = 0; m_vld = 0; m_ovr = 0; m_len = 0;
        end else if (eor_i && pcheck_i && byte_i == SYNC) begin
          m_ovr = 1;
        end
      end else if (fq.size() == 0) begin
        if (eor_i && pcheck_i && byte_i == SYNC) begin
          fq.push_back(byte_i);
          m_idle = 0;
        end
      end else if (eor_i) begin
        m_idle = 0;
        if (!pcheck_i) m_reject(1);
        else if (fq.size() == 1) begin
          if (byte_i == 0 || int'(byte_i) > MAXLEN) m_reject(2);
          else fq.push_back(byte_i);
        end else if (fq.size() < 2 + int'(fq[1])) begin
          fq.push_back(byte_i);
        end else begin
          logic [7:0] x;
          x = '0;
          for (int i = 1; i < fq.size(); i++) x ^= fq[i];
          if (byte_i == x) begin
            m_pay.delete();
            for (int i = 2; i < fq.size(); i++) m_pay.push_back(fq[i]);
            m_len  = int'(fq[1]);
            m_hold = 1; m_vld = 1; m_code = 0;
            fq.delete();
          end else m_reject(3);
        end
      end else begin
        m_idle++;
        if (m_idle == TMO - 1) m_reject(4);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("frame_vld", frame_vld_o, m_vld);
      check("frame_err", frame_err_o, m_err);
      check("err_code", err_code_o, m_code);
      check("overrun", overrun_o, m_ovr);
      check("perr_cnt", perr_cnt_o, m_perr);
      if (m_vld) begin
        check("len", len_o, m_len);
        check("rd_data", rd_data_o, (int'(rd_addr_i) < m_len) ? m_pay[rd_addr_i] : 8'h00);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic p);
    byte_i = b; pcheck_i = p; eor_i = 1'b1;
    @(posedge clk); #1;
    eor_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ack_pulse();
    ack_i = 1'b1;
    @(posedge clk); #1;
    ack_i = 1'b0;
  endtask

  logic [7:0] exp_a [4] = '{8'h11, 8'h22, 8'h33, 8'h00};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", frame_vld_o, 0);
    check("rst_len", len_o, 0);
    check("rst_rd", rd_data_o, 0);
    check("rst_code", err_code_o, 0);
    check("rst_perr", perr_cnt_o, 0);
    rst_n = 1'b1;
    idle(2);

    // Valid frame: A5,03,11,22,33,03
    send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h03, 1);
    check("a_vld", frame_vld_o, 1);
    check("a_len", len_o, 3);
    for (int a = 0; a < 4; a++) begin
      rd_addr_i = 4'(a);
      #1;
      check("a_rd", rd_data_o, exp_a[a]);
    end
    // Sync during hold: overrun, buffer untouched
    send(8'hA5, 1);
    check("ovr_set", overrun_o, 1);
    rd_addr_i = 4'd1;
    #1;
    check("ovr_buf", rd_data_o, 8'h22);
    ack_pulse();
    check("ack_vld", frame_vld_o, 0);
    check("ack_ovr", overrun_o, 0);
    idle(2);

    // Bad checksum
    send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h04, 1);
    check("chk_err", frame_err_o, 1);
    check("chk_code", err_code_o, 3);
    check("chk_vld", frame_vld_o, 0);
    idle(2);

    // Length errors
    send(8'hA5, 1); send(8'h00, 1);
    check("len0_code", err_code_o, 2);
    idle(1);
    send(8'hA5, 1); send(8'h09, 1);
    check("len9_err", frame_err_o, 1);
    check("len9_code", err_code_o, 2);
    idle(1);

    // Garbage then a valid frame A5,02,0F,F0,FD
    send(8'h00, 1); send(8'hFF, 1);
    send(8'hA5, 1); send(8'h02, 1); send(8'h0F, 1); send(8'hF0, 1); send(8'hFD, 1);
    check("g_vld", frame_vld_o, 1);
    check("g_len", len_o, 2);
    check("g_code", err_code_o, 0);
    rd_addr_i = 4'd1;
    #1;
    check("g_rd1", rd_data_o, 8'hF0);
    ack_pulse();
    idle(2);

    // Timeout: A5,02,55 then silence
    send(8'hA5, 1); send(8'h02, 1); send(8'h55, 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); n++; #1;
      if (frame_err_o) break;
    end
    check("tmo_cycles", n, TMO - 1);
    check("tmo_code", err_code_o, 4);
    idle(2);

    // Parity error inside a frame, then saturation of the counter
    send(8'hA5, 1); send(8'h02, 1); send(8'h77, 0);
    check("par_code", err_code_o, 1);
    check("par_cnt1", perr_cnt_o, 1);
    for (int i = 0; i < 299; i++) send(8'h00, 0);
    check("par_sat", perr_cnt_o, 255);
    idle(2);

    // Reset mid-payload
    send(8'hA5, 1); send(8'h04, 1); send(8'h01, 1); send(8'h02, 1);
    #2 rst_n = 1'b0;
    rd_addr_i = 4'd0;
    #1;
    check("mid_vld", frame_vld_o, 0);
    check("mid_len", len_o, 0);
    check("mid_rd", rd_data_o, 0);
    check("mid_code", err_code_o, 0);
    check("mid_perr", perr_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Frame after reset: A5,01,7E,7F
    send(8'hA5, 1); send(8'h01, 1); send(8'h7E, 1); send(8'h7F, 1);
    check("post_vld", frame_vld_o, 1);
    check("post_rd", rd_data_o, 8'h7E);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
